// File: rtl/uart_wr_arbiter.sv
// uart_wr_arbiter: round-robin arbiter sharing the single UART register write
// port among N requesters. One outstanding write at a time. The winner's
// address/data are latched at grant and the result comes back as a one-cycle
// completion pulse with error status. A watchdog aborts writes the UART never
// accepts.
module uart_wr_arbiter #(
    parameter int N       = 4,
    parameter int DW      = 8,
    parameter int AW      = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_valid_i,
    input  logic [N*DW-1:0] req_data_i,
    input  logic [N*AW-1:0] req_addr_i,
    output logic [N-1:0]    req_ready_o,
    output logic [N-1:0]    req_err_o,
    output logic [N-1:0]    grant_o,
    output logic            busy_o,
    output logic            wr_valid_o,
    output logic [DW-1:0]   wr_data_o,
    output logic [AW-1:0]   wr_addr_o,
    input  logic            wr_ready_i,
    input  logic            wr_err_i
);

    localparam int LW = $clog2(N);
    localparam int WW = $clog2(TIMEOUT);

    // Requester 0 wins first after reset because the search starts at last+1.
    localparam logic [LW-1:0] LAST_RST = LW'(N - 1);
    // Final watchdog count: hitting it with no acceptance aborts the write.
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   last_q, last_d;
    logic [LW-1:0]   owner_q, owner_d;
    logic [WW-1:0]   wd_q, wd_d;
    logic            wr_valid_q, wr_valid_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [N-1:0]    req_ready_q, req_ready_d;
    logic [N-1:0]    req_err_q, req_err_d;
    logic            busy_q, busy_d;

    logic            win_found;
    logic [LW-1:0]   win_idx;
    logic [LW-1:0]   cand_idx;
    logic [DW-1:0]   win_data;
    logic [AW-1:0]   win_addr;
    logic            finish;
    logic            finish_err;

    // Round-robin search: first set request bit starting just after the last owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int i = 1; i <= N; i++) begin
            cand_idx = LW'((int'(last_q) + i) % N);
            if (!win_found && req_valid_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Mux out the winner's data and address slices.
    always_comb begin
        win_data = '0;
        win_addr = '0;
        for (int k = 0; k < N; k++) begin
            if (win_idx == LW'(k)) begin
                win_data = req_data_i[k*DW +: DW];
                win_addr = req_addr_i[k*AW +: AW];
            end
        end
    end

    // Completion decision while issuing; acceptance beats a same-cycle timeout.
    always_comb begin
        finish     = 1'b0;
        finish_err = 1'b0;
        if (state_q == ISSUE) begin
            if (wr_valid_q && wr_ready_i) begin
                finish     = 1'b1;
                finish_err = wr_err_i;
            end else if (wd_q == WD_LAST) begin
                finish     = 1'b1;
                finish_err = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        wd_d        = wd_q;
        wr_valid_d  = wr_valid_q;
        wr_data_d   = wr_data_q;
        wr_addr_d   = wr_addr_q;
        grant_d     = grant_q;
        req_ready_d = '0;
        req_err_d   = '0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = ISSUE;
                    owner_d    = win_idx;
                    wr_data_d  = win_data;
                    wr_addr_d  = win_addr;
                    grant_d    = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    wr_valid_d = 1'b1;
                    wd_d       = '0;
                end
            end

            ISSUE: begin
                if (finish) begin
                    state_d     = DONE;
                    wr_valid_d  = 1'b0;
                    grant_d     = '0;
                    req_ready_d = grant_q;
                    req_err_d   = grant_q & {N{finish_err}};
                    last_d      = owner_q;
                end else if (!wr_ready_i && wd_q != WD_LAST) begin
                    // Saturating count of cycles the UART has not been ready.
                    wd_d = wd_q + 1'b1;
                end
            end

            DONE: begin
                // Unconditional return guarantees a cycle with wr_valid low.
                state_d = IDLE;
            end

            default: begin
                state_d    = IDLE;
                wr_valid_d = 1'b0;
                grant_d    = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            last_q      <= LAST_RST;
            owner_q     <= '0;
            wd_q        <= '0;
            wr_valid_q  <= 1'b0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            grant_q     <= '0;
            req_ready_q <= '0;
            req_err_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            wd_q        <= wd_d;
            wr_valid_q  <= wr_valid_d;
            wr_data_q   <= wr_data_d;
            wr_addr_q   <= wr_addr_d;
            grant_q     <= grant_d;
            req_ready_q <= req_ready_d;
            req_err_q   <= req_err_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign req_err_o   = req_err_q;
    assign grant_o     = grant_q;
    assign busy_o      = busy_q;
    assign wr_valid_o  = wr_valid_q;
    assign wr_data_o   = wr_data_q;
    assign wr_addr_o   = wr_addr_q;

endmodule

// File: tb/tb_uart_wr_arbiter.sv
// Testbench for uart_wr_arbiter: directed scenarios with literal expectations
// plus randomized traffic, all continuously checked against a transaction-level
// reference model of the arbiter.
module tb_uart_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    rv;
    logic [N*DW-1:0] rd;
    logic [N*AW-1:0] ra;
    logic [N-1:0]    req_ready_o, req_err_o, grant_o;
    logic            busy_o, wr_valid_o;
    logic [DW-1:0]   wr_data_o;
    logic [AW-1:0]   wr_addr_o;
    logic            wr_ready, wr_err;

    uart_wr_arbiter #(.N(N), .DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(rv),
        .req_data_i (rd),
        .req_addr_i (ra),
        .req_ready_o(req_ready_o),
        .req_err_o  (req_err_o),
        .grant_o    (grant_o),
        .busy_o     (busy_o),
        .wr_valid_o (wr_valid_o),
        .wr_data_o  (wr_data_o),
        .wr_addr_o  (wr_addr_o),
        .wr_ready_i (wr_ready),
        .wr_err_i   (wr_err)
    );

    always #5 clk = ~clk;

    int compares = 0;
    int fails    = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    // ---------------- reference model (transaction level) ----------------
    int            m_owner;   // requester being served, -1 when none
    int            m_age;     // cycles spent waiting with ready low
    int            m_last;
    bit            m_gap;     // completion cycle in progress
    bit            m_fin, m_ferr;
    logic          e_valid, e_busy;
    logic [DW-1:0] e_data;
    logic [AW-1:0] e_addr;
    logic [N-1:0]  e_grant, e_rdy, e_err;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_owner = -1; m_gap = 0; m_last = N - 1; m_age = 0;
            e_valid = 0; e_data = '0; e_addr = '0; e_grant = '0;
            e_rdy = '0; e_err = '0; e_busy = 0;
        end else begin
            e_rdy = '0;
            e_err = '0;
            if (m_gap) begin
                m_gap  = 0;
                e_busy = 0;
            end else if (m_owner >= 0) begin
                m_fin = 0; m_ferr = 0;
                if (wr_ready) begin
                    m_fin = 1; m_ferr = wr_err;
                end else if (m_age == TO - 1) begin
                    m_fin = 1; m_ferr = 1;
                end else begin
                    m_age++;
                end
                if (m_fin) begin
                    e_rdy[m_owner] = 1'b1;
                    e_err[m_owner] = m_ferr;
                    m_last  = m_owner;
                    m_owner = -1;
                    m_gap   = 1;
                    e_valid = 0;
                    e_grant = '0;
                end
            end else if (rv != '0) begin
                for (int i = 1; i <= N; i++)
                    if (m_owner < 0 && rv[(m_last + i) % N]) m_owner = (m_last + i) % N;
                m_age   = 0;
                e_valid = 1;
                e_data  = rd[m_owner*DW +: DW];
                e_addr  = ra[m_owner*AW +: AW];
                e_grant = '0;
                e_grant[m_owner] = 1'b1;
                e_busy  = 1;
            end
        end
        chk_en = 1;
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            compares++;
            if ({wr_valid_o, wr_data_o, wr_addr_o, grant_o, req_ready_o, req_err_o & req_ready_o, busy_o} !==
                {e_valid, e_data, e_addr, e_grant, e_rdy, e_err & e_rdy, e_busy}) begin
                fails++;
                $display("FAIL model cyc=%0d: got v=%b d=%h a=%h g=%b r=%b e=%b b=%b, want v=%b d=%h a=%h g=%b r=%b e=%b b=%b",
                         cyc, wr_valid_o, wr_data_o, wr_addr_o, grant_o, req_ready_o, req_err_o, busy_o,
                         e_valid, e_data, e_addr, e_grant, e_rdy, e_err, e_busy);
            end
        end
    end

    // ---------------- monitor for directed scenarios ----------------
    int            vlen = 0, last_vlen = 0, rise_cyc = 0, pulse_cyc = 0, pulse_cnt = 0;
    int            rrun = 0, max_rrun = 0;
    bit            prev_v = 0, unstable = 0;
    logic [N-1:0]  prev_g = '0, last_rdy = '0, last_err = '0;
    logic [DW-1:0] cap_data = '0;
    logic [AW-1:0] cap_addr = '0;
    int            gq[$];
    int            gt[$];
    int            gi;

    always @(negedge clk) begin
        if (wr_valid_o) begin
            if (!prev_v) begin
                cap_data = wr_data_o; cap_addr = wr_addr_o; rise_cyc = cyc;
            end else if (wr_data_o !== cap_data || wr_addr_o !== cap_addr) begin
                unstable = 1;
            end
            vlen++;
        end else if (vlen > 0) begin
            last_vlen = vlen; vlen = 0;
        end
        prev_v = wr_valid_o;
        if (grant_o != '0 && prev_g == '0) begin
            gi = -1;
            for (int b = 0; b < N; b++) if (grant_o[b]) gi = b;
            gq.push_back(gi);
            gt.push_back(cyc);
        end
        prev_g = grant_o;
        if (req_ready_o != '0) begin
            pulse_cnt++; last_rdy = req_ready_o; last_err = req_err_o; pulse_cyc = cyc;
            rrun++;
            if (rrun > max_rrun) max_rrun = rrun;
        end else begin
            rrun = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        compares++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        compares++;
        fails++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    task automatic wait_valid(input string nm, input int max);
        int n = 0;
        while (!wr_valid_o && n < max) begin tick(); n++; end
        if (!wr_valid_o) bound_fail(nm);
    endtask

    task automatic wait_pulse(input string nm, input int max);
        int n = 0;
        while (req_ready_o == '0 && n < max) begin tick(); n++; end
        if (req_ready_o == '0) bound_fail(nm);
    endtask

    task automatic wait_idle(input string nm, input int max);
        int n = 0;
        while (busy_o && n < max) begin tick(); n++; end
        if (busy_o) bound_fail(nm);
    endtask

    task automatic do_reset();
        rst = 1; rv = '0; tick(); tick();
        rst = 0; unstable = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int mode;
        int pc;
        rst = 1; rv = '0; rd = '0; ra = '0; wr_ready = 1; wr_err = 0;
        tick(); tick();

        // Reset state
        chk("reset wr_valid", int'(wr_valid_o), 0);
        chk("reset wr_data",  int'(wr_data_o), 0);
        chk("reset grant",    int'(grant_o), 0);
        chk("reset ready/err", int'({req_ready_o, req_err_o}), 0);
        chk("reset busy",     int'(busy_o), 0);
        rst = 0;
        tick();

        // Single request, UART always ready
        ra[3:0] = 4'd4; rd[7:0] = 8'hA5; wr_ready = 1; rv = 4'b0001;
        wait_pulse("single pulse", 10);
        rv = '0; tick();
        chk("single addr",   int'(cap_addr), 4);
        chk("single data",   int'(cap_data), 'hA5);
        chk("single vlen",   last_vlen, 1);
        chk("single ready",  int'(last_rdy), 'b0001);
        chk("single err",    int'(last_err), 0);

        // All four held, round-robin 0,1,2,3,0 at one write per 3 cycles
        do_reset();
        rd = 32'h44332211; ra = 16'h4321;
        gq.delete(); gt.delete(); max_rrun = 0;
        rv = 4'b1111; wr_ready = 1;
        n = 0;
        while (gq.size() < 5 && n < 40) begin tick(); n++; end
        rv = '0;
        wait_idle("rr idle", 10);
        tick();
        if (gq.size() < 5) bound_fail("rr grants");
        else begin
            for (int i = 0; i < 5; i++) chk($sformatf("rr grant[%0d]", i), gq[i], i % N);
            chk("rr spacing", gt[1] - gt[0], 3);
            chk("rr span",    gt[4] - gt[0], 12);
        end
        chk("rr pulse width", max_rrun, 1);

        // UART stalls ready low for 5 cycles
        do_reset();
        wr_ready = 0; wr_err = 0;
        rd[23:16] = 8'h3C; ra[11:8] = 4'd7; rv = 4'b0100;
        wait_valid("stall grant", 10);
        repeat (5) tick();
        chk("stall valid held", int'(wr_valid_o), 1);
        wr_ready = 1;
        wait_pulse("stall pulse", 5);
        rv = '0; tick();
        chk("stall latency", pulse_cyc - rise_cyc, 6);
        chk("stall vlen",    last_vlen, 6);
        chk("stall stable",  int'(unstable), 0);
        chk("stall ready",   int'(last_rdy), 'b0100);
        chk("stall err",     int'(last_err), 0);

        // Error reported by UART at acceptance
        wr_ready = 1; wr_err = 1; rv = 4'b0010;
        wait_pulse("err pulse", 10);
        rv = '0; tick(); wr_err = 0;
        chk("uart err ready", int'(last_rdy), 'b0010);
        chk("uart err flag",  int'(last_err), 'b0010);

        // Watchdog timeout, then normal service
        do_reset();
        wr_ready = 0; rd[7:0] = 8'h5A; rv = 4'b0001;
        wait_pulse("timeout pulse", 40);
        rv = '0; tick();
        chk("timeout vlen",    last_vlen, TO);
        chk("timeout latency", pulse_cyc - rise_cyc, TO);
        chk("timeout ready",   int'(last_rdy), 'b0001);
        chk("timeout err",     int'(last_err), 'b0001);
        wr_ready = 1; rd[31:24] = 8'hC3; rv = 4'b1000;
        wait_pulse("post-timeout pulse", 10);
        rv = '0; tick();
        chk("post-timeout ready", int'(last_rdy), 'b1000);
        chk("post-timeout err",   int'(last_err), 0);
        chk("post-timeout data",  int'(cap_data), 'hC3);

        // Requester changes data and drops valid after grant
        do_reset();
        wr_ready = 0; rd[23:16] = 8'h11; rv = 4'b0100;
        wait_valid("change grant", 10);
        tick();
        rd[23:16] = 8'h22; rv = '0;
        tick();
        wr_ready = 1;
        wait_pulse("change pulse", 10);
        tick();
        chk("change data",   int'(cap_data), 'h11);
        chk("change stable", int'(unstable), 0);
        chk("change ready",  int'(last_rdy), 'b0100);

        // Reset during ISSUE aborts silently
        do_reset();
        wr_ready = 0; rv = 4'b0010;
        wait_valid("rst grant", 10);
        tick();
        pc = pulse_cnt;
        rst = 1; rv = '0;
        tick();
        chk("rst-mid valid", int'(wr_valid_o), 0);
        chk("rst-mid outs",  int'({grant_o, req_ready_o, busy_o, wr_data_o, wr_addr_o}), 0);
        rst = 0;
        repeat (3) tick();
        chk("rst-mid no pulse", pulse_cnt, pc);
        wr_ready = 1; rv = 4'b1001;
        wait_valid("post-rst grant", 10);
        chk("post-rst grant", int'(grant_o), 'b0001);
        wait_pulse("post-rst pulse", 10);
        rv = '0; tick(); tick();

        // Randomized traffic against the model
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) mode = $urandom_range(0, 2);
            for (int b = 0; b < N; b++) begin
                if (!rv[b]) rv[b] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 9) == 0) rv[b] = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) rd = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 16'($urandom);
            case (mode)
                0:       wr_ready = ($urandom_range(0, 9) != 0);
                1:       wr_ready = $urandom_range(0, 1) == 1;
                default: wr_ready = ($urandom_range(0, 29) == 0);
            endcase
            wr_err = $urandom_range(0, 1) == 1;
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 0; rv = '0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

    // Global safety bound.
    initial begin
        #2000000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/uart_wr_arbiter.md
# uart_wr_arbiter

Round-robin arbiter that shares the single register write port of the `uart` block among `N` independent requesters, such as the boot-time sender and the HDMI/I2C configuration sequencers. It holds at most one outstanding write. It latches the winning requester's address and data, drives the UART write handshake, and returns a one-cycle completion pulse with error status to that requester. A watchdog aborts writes that the UART never accepts.

## Interface
- `N`, 4: number of requesters, 2..8
- `DW`, 8: write data width
- `AW`, 4: UART register address width
- `TIMEOUT`, 1024: cycles to wait for `wr_ready_i` before aborting; must be ≥ 2
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, synchronous, active-high
- `req_valid_i`  in  N  per-requester write request
- `req_data_i`  in  N*DW  requester k data in bits [k*DW +: DW]
- `req_addr_i`  in  N*AW  requester k address in bits [k*AW +: AW]
- `req_ready_o`  out  N  one-cycle completion pulse to the granted requester
- `req_err_o`  out  N  error status; valid only while the matching `req_ready_o` bit is high
- `grant_o`  out  N  one-hot owner of the current transaction; all zero when idle
- `busy_o`  out  1  transaction in flight (state ≠ IDLE)
- `wr_valid_o`  out  1  to `uart.wr_valid_i`
- `wr_data_o`  out  DW  to `uart.wr_data_i`
- `wr_addr_o`  out  AW  to `uart.wr_addr_i`
- `wr_ready_i`  in  1  from `uart.wr_ready_o`
- `wr_err_i`  in  1  from `uart.wr_err_o`

## Operation
- States: IDLE, ISSUE, DONE. Every output is registered.
- IDLE:
  - If any `req_valid_i` bit is set, select a winner by round-robin. The search starts at `(last+1) mod N` and takes the first set bit.
  - Latch the winner's data and address into `wr_data_o`/`wr_addr_o`.
  - Set `grant_o` one-hot, set `wr_valid_o=1`, clear the watchdog, and go to ISSUE.
- ISSUE: the UART accepts the write when `wr_valid_o && wr_ready_i`. On acceptance:
  - Clear `wr_valid_o`.
  - Pulse `req_ready_o[g]` next cycle, with `req_err_o[g] = wr_err_i` sampled in the acceptance cycle.
  - Set `last<=g` and go to DONE.
- ISSUE watchdog: the counter increments each cycle in which `wr_ready_i` is low. When it reaches `TIMEOUT-1`, the block:
  - clears `wr_valid_o`;
  - pulses `req_ready_o[g]` with `req_err_o[g]=1`;
  - sets `last<=g` and goes to DONE.
- DONE:
  - `req_ready_o`/`req_err_o` are high for this single cycle.
  - `grant_o` is cleared.
  - The next state is IDLE unconditionally. This gives the UART a guaranteed one-cycle gap with `wr_valid_o` low between writes.
- Requester rule: hold `req_valid_i`, data and address until your `req_ready_o` pulse.
  - Data is latched at grant, so changes after grant are ignored.
  - Dropping `req_valid_i` after grant does not cancel the write; the pulse still arrives.
- Round-robin pointer `last` is `$clog2(N)` bits. On reset it is N-1, so requester 0 has first priority.
- Watchdog width is `$clog2(TIMEOUT)` bits. It saturates and never wraps.

## Timing
- Reset state (all synchronous):
  - state=IDLE, `last`=N-1, watchdog=0;
  - `wr_valid_o`=0, `wr_data_o`=0, `wr_addr_o`=0;
  - `grant_o`=0, `req_ready_o`=0, `req_err_o`=0, `busy_o`=0.
- Latency (request first seen in IDLE at cycle t; UART ready at cycle t+1):
  - `wr_valid_o`/`grant_o` high at t+1;
  - acceptance at t+1;
  - `req_ready_o` pulse at t+2;
  - IDLE at t+3.
  - With continuous requests, the next grant lands at t+4. Peak throughput is one write per 3 cycles.
- If `wr_ready_i` is first high k cycles after `wr_valid_o` rises, the pulse arrives k+1 cycles after grant.
- Timeout: with `wr_ready_i` held low, the error pulse comes `TIMEOUT` cycles after `wr_valid_o` rises.
- `wr_ready_i` high in the same cycle the watchdog expires: treat it as acceptance, so `err` = `wr_err_i`, not timeout.
- Simultaneous requests in IDLE: only the winner is granted. Losers stay pending with no pulse.
- New requests arriving during ISSUE/DONE are not observed until IDLE.
- `wr_ready_i` and `wr_err_i` are ignored outside ISSUE.
- `rst_i` asserted mid-transaction: abort silently with no pulse. `wr_valid_o` is low in the cycle after reset sampling.

## Test plan
- Single request, UART always ready:
  - Stimulus: `req_valid_i`=0001, addr 4, data 0xA5.
  - Required: `wr_valid_o`=1 with addr 4 / data 0xA5 for exactly 1 cycle, then `req_ready_o`=0001, `req_err_o`=0.
- All four requesters held valid, UART always ready:
  - Required: grants 0,1,2,3,0,… one write every 3 cycles, each `req_ready_o` pulse one cycle wide.
- UART stalls `wr_ready_i` low for 5 cycles:
  - Required: `wr_valid_o` stays high with data stable for those 5 cycles, then completion 1 cycle after ready.
  - Separately, with `wr_err_i`=1 at acceptance: `req_err_o`=1.
- `TIMEOUT`=16 with `wr_ready_i` stuck low:
  - Required: `wr_valid_o` drops after 16 cycles and `req_ready_o`/`req_err_o` pulse together.
  - Next request is served normally afterwards.
- Requester 2 changes data 0x11→0x22 and drops valid one cycle after grant:
  - Required: UART receives 0x11 and requester 2 still gets the pulse.
- `rst_i` asserted while in ISSUE:
  - Required: all outputs at reset values the next cycle, no pulse.
  - First post-reset grant goes to requester 0 when 0 and 3 request together.
